// File: rtl/fft8_bitrev_reorder.sv
`default_nettype none
// ============================================================================
// Module   : fft8_bitrev_reorder
// Brief    : Ping-pong reorder buffer turning bit-reversed 8-point FFT frames
//            into natural frequency order, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module fft8_bitrev_reorder #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_r,
    input  logic [W-1:0] in_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_r,
    output logic [W-1:0] out_im,
    output logic [2:0]   out_idx,
    output logic         out_last
);

    logic [2*W-1:0] r_mem [0:1][0:7];

    logic [1:0]     r_full;
    logic           r_wr_bank;
    logic           r_rd_bank;
    logic [2:0]     r_wr_cnt;
    logic [2:0]     r_rd_cnt;

    logic [1:0]     w_full_nxt;
    logic           w_accept;
    logic           w_load;
    logic           w_wr_done;
    logic           w_rd_done;
    logic [2:0]     w_wr_addr;
    logic [2*W-1:0] w_rd_word;

    assign in_ready  = !r_full[r_wr_bank];
    assign w_accept  = in_valid && in_ready;
    assign w_load    = (!out_valid || out_ready) && r_full[r_rd_bank];
    assign w_wr_done = w_accept && (r_wr_cnt == 3'd7);
    assign w_rd_done = w_load && (r_rd_cnt == 3'd7);
    // Arrival i of a frame is frequency bin bitrev(i), so store it there.
    assign w_wr_addr = {r_wr_cnt[0], r_wr_cnt[1], r_wr_cnt[2]};
    assign w_rd_word = r_mem[r_rd_bank][r_rd_cnt];

    // Set and clear always target different banks, so both can apply.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_done) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_rd_done) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_bank][w_wr_addr] <= {in_r, in_im};
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= 3'd0;
            r_rd_cnt  <= 3'd0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_im    <= '0;
            out_idx   <= 3'd0;
            out_last  <= 1'b0;
        end else begin
            r_full <= w_full_nxt;

            if (w_accept) begin
                r_wr_cnt <= r_wr_cnt + 3'd1;
                if (w_wr_done) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end

            if (w_load) begin
                out_r     <= w_rd_word[2*W-1:W];
                out_im    <= w_rd_word[W-1:0];
                out_idx   <= r_rd_cnt;
                out_last  <= (r_rd_cnt == 3'd7);
                out_valid <= 1'b1;
                r_rd_cnt  <= r_rd_cnt + 3'd1;
                if (w_rd_done) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
